// File: rtl/cam_config.sv
// Camera register loader: after a power-up wait, walks a constant register table
// and issues one SCCB write per entry, with table-driven delays and a write timeout.
module cam_config #(
    parameter logic [7:0]  DEV_ID      = 8'h42,
    parameter int unsigned PWRUP_CYC   = 24_000,
    parameter int unsigned DELAY_CYC   = 240_000,
    parameter int unsigned TIMEOUT_CYC = 4_800
) (
    input  logic       clk_24,
    input  logic       reset_n,
    input  logic       start,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [7:0] wr_id,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_done,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] idx
);

    localparam int unsigned CNT_W = 18;
    localparam int unsigned IDX_W = 8;
    localparam int unsigned ENT_W = 16;

    localparam logic [ENT_W-1:0] ENT_END   = 16'hFFFF;
    localparam logic [ENT_W-1:0] ENT_DELAY = 16'hFFF0;
    localparam logic [IDX_W-1:0] IDX_LAST  = 8'hFF;

    localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PWRUP, S_FETCH, S_ISSUE, S_WAIT_DONE, S_DELAY, S_FINISH, S_FAIL
    } state_t;

    // Register table {addr, data}; unlisted entries read as end-of-table.
    function automatic logic [ENT_W-1:0] rom(input logic [IDX_W-1:0] a);
        case (a)
            8'd0:    rom = 16'h1280;
            8'd1:    rom = ENT_DELAY;
            8'd2:    rom = 16'h1101;
            8'd3:    rom = 16'h0C04;
            8'd4:    rom = 16'h3A04;
            default: rom = ENT_END;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic               wr_valid_q, wr_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [ENT_W-1:0]   entry_c;

    assign entry_c = rom(idx_q);

    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_valid_q <= wr_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_PWRUP;
            S_PWRUP:     if (cnt_q == PWRUP_LAST) state_d = S_FETCH;
            S_FETCH: begin
                if (entry_c == ENT_END)        state_d = S_FINISH;
                else if (entry_c == ENT_DELAY) state_d = S_DELAY;
                else                           state_d = S_ISSUE;
            end
            S_ISSUE:     if (wr_valid_q && wr_ready) state_d = S_WAIT_DONE;
            // A completion in the last allowed cycle still wins over the timeout.
            S_WAIT_DONE: begin
                if (wr_done)                    state_d = (idx_q == IDX_LAST) ? S_FINISH : S_FETCH;
                else if (cnt_q == TIMEOUT_LAST) state_d = S_FAIL;
            end
            S_DELAY:     if (cnt_q == DELAY_LAST)
                             state_d = (idx_q == IDX_LAST) ? S_FINISH : S_FETCH;
            S_FINISH,
            S_FAIL:      if (!start) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Next register values; the wait counter restarts on every state change.
    always_comb begin
        cnt_d      = '0;
        idx_d      = idx_q;
        addr_d     = addr_q;
        data_d     = data_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        wr_valid_d = (state_d == S_ISSUE);

        if ((state_d == state_q) &&
            (state_q == S_PWRUP || state_q == S_DELAY || state_q == S_WAIT_DONE))
            cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: if (state_d == S_PWRUP) begin
                busy_d = 1'b1;
                done_d = 1'b0;
                err_d  = 1'b0;
                idx_d  = '0;
            end
            S_FETCH: if (state_d == S_ISSUE) begin
                addr_d = entry_c[15:8];
                data_d = entry_c[7:0];
            end
            S_WAIT_DONE,
            S_DELAY: if (state_d == S_FETCH) idx_d = idx_q + IDX_W'(1);
            default: ;
        endcase

        if (state_d == S_FINISH && state_q != S_FINISH) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
        if (state_d == S_FAIL && state_q != S_FAIL) begin
            err_d  = 1'b1;
            busy_d = 1'b0;
        end
    end

    assign wr_id    = DEV_ID;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = addr_q;
    assign wr_data  = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign idx      = idx_q;

endmodule
